// File: rtl/alu_bist_driver_if.sv
// Operand/result bus between the BIST driver (master) and the ALU under test (slave).
// Driver owns A/B/opcode; the ALU returns Result ALU_LATENCY cycles after it samples them.
interface alu_bist_driver_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [2:0]       opcode;
    logic [WIDTH:0]   Result;

    modport master (
        output A,
        output B,
        output opcode,
        input  Result
    );

    modport slave (
        input  A,
        input  B,
        input  opcode,
        output Result
    );
endinterface

// File: rtl/alu_bist_driver.sv
// LFSR-driven ALU self-test: one vector per ALU_LATENCY+1 cycles, Result checked against a golden model.
// No backpressure; start is ignored while busy. ALU_BIST_STOP_ON_FAIL_EN ends the run at the first mismatch.
module alu_bist_driver #(
    parameter int WIDTH       = 8,
    parameter int ALU_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic [31:0]      seed_i,
    input  logic [CNT_W-1:0] num_vectors_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [CNT_W-1:0] fail_cnt_o,
    alu_bist_driver_if.master alu
);

    localparam int WC_W = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [31:0]      lfsr_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       op_q;
    logic [WIDTH:0]   exp_q;
    logic [WC_W-1:0]  wait_cnt_q;
    logic [CNT_W-1:0] remain_q;
    logic [CNT_W-1:0] pass_q;
    logic [CNT_W-1:0] fail_q;
    logic             busy_q;
    logic             done_q;

    logic [31:0]      seed_d;
    logic             match_d;
    logic             halt_d;

    function automatic logic [31:0] lfsr_step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [2:0]       op);
        logic [WIDTH:0] r;
        case (op)
            3'd0:    r = {1'b0, a} + {1'b0, b};
            3'd1:    r = {1'b0, a} - {1'b0, b};
            3'd2:    r = {1'b0, a & b};
            3'd3:    r = {1'b0, a | b};
            3'd4:    r = {1'b0, a ^ b};
            3'd5:    r = {1'b0, ~(a & b)};
            3'd6:    r = {a, 1'b0};
            default: r = {1'b0, a >> 1};
        endcase
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        seed_d  = (seed_i == 32'd0) ? 32'h1 : seed_i;
        match_d = (alu.Result == exp_q);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        halt_d  = !match_d;
`else
        halt_d  = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            lfsr_q     <= 32'h1;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            exp_q      <= '0;
            wait_cnt_q <= '0;
            remain_q   <= '0;
            pass_q     <= '0;
            fail_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        pass_q     <= '0;
                        fail_q     <= '0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        remain_q   <= num_vectors_i;
                        wait_cnt_q <= '0;
                        state_q    <= WAIT;
                        if (num_vectors_i != '0) begin
                            // Vector 0 comes straight from the seed; the LFSR then points at vector 1.
                            a_q    <= seed_d[WIDTH-1:0];
                            b_q    <= seed_d[2*WIDTH-1:WIDTH];
                            op_q   <= seed_d[31:29];
                            exp_q  <= golden(seed_d[WIDTH-1:0], seed_d[2*WIDTH-1:WIDTH], seed_d[31:29]);
                            lfsr_q <= lfsr_step(seed_d);
                        end else begin
                            lfsr_q <= seed_d;
                        end
                    end
                end
                WAIT: begin
                    if (remain_q == '0) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (wait_cnt_q == WC_W'(ALU_LATENCY)) begin
                        if (match_d) begin
                            pass_q <= sat_inc(pass_q);
                        end else begin
                            fail_q <= sat_inc(fail_q);
                        end
                        remain_q <= remain_q - CNT_W'(1);
                        if (remain_q == CNT_W'(1) || halt_d) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            a_q        <= lfsr_q[WIDTH-1:0];
                            b_q        <= lfsr_q[2*WIDTH-1:WIDTH];
                            op_q       <= lfsr_q[31:29];
                            exp_q      <= golden(lfsr_q[WIDTH-1:0], lfsr_q[2*WIDTH-1:WIDTH], lfsr_q[31:29]);
                            lfsr_q     <= lfsr_step(lfsr_q);
                            wait_cnt_q <= '0;
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + WC_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign alu.A      = a_q;
    assign alu.B      = b_q;
    assign alu.opcode = op_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign pass_cnt_o = pass_q;
    assign fail_cnt_o = fail_q;

endmodule

// File: tb/tb_alu_bist_driver.sv
// Directed bench for alu_bist_driver with a registered behavioural ALU (latency 1) and an LFSR mirror.
module tb_alu_bist_driver;
    localparam int W   = 8;
    localparam int LAT = 1;
    localparam int CW  = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start_i;
    logic [31:0]   seed_i;
    logic [CW-1:0] num_vectors_i;
    logic          busy_o;
    logic          done_o;
    logic [CW-1:0] pass_cnt_o;
    logic [CW-1:0] fail_cnt_o;
    logic          stuck;
    logic [W:0]    res_q;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_bist_driver_if #(.WIDTH(W)) bus ();

    alu_bist_driver #(.WIDTH(W), .ALU_LATENCY(LAT), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_i       (start_i),
        .seed_i        (seed_i),
        .num_vectors_i (num_vectors_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .pass_cnt_o    (pass_cnt_o),
        .fail_cnt_o    (fail_cnt_o),
        .alu           (bus.master)
    );

    function automatic logic [31:0] step(input logic [31:0] l);
        return {l[30:0], l[31] ^ l[21] ^ l[1] ^ l[0]};
    endfunction

    // Reference ALU written with integer arithmetic, independent of bit-slicing tricks.
    function automatic logic [W:0] ref_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            3'd0:    r = ia + ib;
            3'd1:    r = (ia - ib + 512) % 512;
            3'd2:    r = ia & ib;
            3'd3:    r = ia | ib;
            3'd4:    r = ia ^ ib;
            3'd5:    r = 255 - (ia & ib);
            3'd6:    r = ia * 2;
            default: r = ia / 2;
        endcase
        return r[W:0];
    endfunction

    always @(posedge clk) res_q <= ref_res(bus.A, bus.B, bus.opcode);
    assign bus.Result = stuck ? '0 : res_q;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic start_run(input logic [31:0] s, input logic [CW-1:0] n);
        @(negedge clk);
        start_i       = 1'b1;
        seed_i        = s;
        num_vectors_i = n;
        @(posedge clk);
        #1;
        start_i = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int cycles);
        cycles = 0;
        while (!done_o && cycles < bound) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("done_timeout", 64'(done_o), 64'd1);
    endtask

    // Follows the run edge by edge, checking each issued vector against the mirror.
    task automatic run_full(input logic [31:0] s, input int n);
        logic [31:0] l;
        start_run(s, CW'(n));
        l = (s == 32'd0) ? 32'h1 : s;
        for (int k = 0; k < n; k++) begin
            check("vector", 64'({bus.A, bus.B, bus.opcode}), 64'({l[7:0], l[15:8], l[31:29]}));
            check("busy_run", 64'({busy_o, done_o}), 64'b10);
            l = step(l);
            repeat (LAT + 1) @(posedge clk);
            #1;
        end
        check("end_flags", 64'({busy_o, done_o}), 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          cyc;
        int          exp_fail;
        int          first;
        logic [31:0] l;
        logic [18:0] first_vec;

        rst_n = 1'b0; start_i = 1'b0; seed_i = '0; num_vectors_i = '0; stuck = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_flags", 64'({busy_o, done_o}), 64'b00);
        check("rst_bus", 64'({bus.A, bus.B, bus.opcode}), 64'd0);
        check("rst_cnts", 64'({pass_cnt_o, fail_cnt_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full 100-vector run against a correct ALU.
        run_full(32'hACE1, 100);
        check("t1_pass", 64'(pass_cnt_o), 64'd100);
        check("t1_fail", 64'(fail_cnt_o), 64'd0);

        // Zero-length run: done one edge after start, counters cleared.
        start_run(32'h55, '0);
        check("n0_busy", 64'({busy_o, done_o}), 64'b10);
        @(posedge clk);
        #1;
        check("n0_done", 64'({busy_o, done_o}), 64'b01);
        check("n0_cnts", 64'({pass_cnt_o, fail_cnt_o}), 64'd0);

        // Seed 0 is replaced by 1: A=1, B=0, opcode=0.
        run_full(32'h0, 1);
        check("seed0_pass", 64'(pass_cnt_o), 64'd1);

        // Result stuck at zero.
        stuck = 1'b1;
        l = 32'h1234_5678;
        exp_fail = 0;
        first = -1;
        first_vec = '0;
        for (int k = 0; k < 20; k++) begin
            if (ref_res(l[7:0], l[15:8], l[31:29]) != '0) begin
                exp_fail++;
                if (first < 0) begin
                    first = k;
                    first_vec = {l[7:0], l[15:8], l[31:29]};
                end
            end
            l = step(l);
        end
        start_run(32'h1234_5678, CW'(20));
        wait_done(200, cyc);
`ifdef ALU_BIST_STOP_ON_FAIL_EN
        check("stop_fail", 64'(fail_cnt_o), 64'd1);
        check("stop_pass", 64'(pass_cnt_o), 64'(first));
        check("stop_cycles", 64'(cyc), 64'((first + 1) * (LAT + 1)));
        repeat (6) @(posedge clk);
        #1;
        check("stop_vec_hold", 64'({bus.A, bus.B, bus.opcode}), 64'(first_vec));
        check("stop_flags", 64'({busy_o, done_o}), 64'b01);
`else
        check("stuck_total", 64'(pass_cnt_o + fail_cnt_o), 64'd20);
        check("stuck_fail", 64'(fail_cnt_o), 64'(exp_fail));
        check("stuck_cycles", 64'(cyc), 64'(20 * (LAT + 1)));
`endif
        stuck = 1'b0;

        // start pulsed mid-run is ignored.
        start_run(32'hBEEF_0001, CW'(10));
        repeat (4) @(posedge clk);
        @(negedge clk);
        start_i = 1'b1; seed_i = 32'h0F0F_0F0F; num_vectors_i = CW'(3);
        @(posedge clk);
        #1;
        start_i = 1'b0;
        check("ign_busy", 64'(busy_o), 64'd1);
        wait_done(100, cyc);
        check("ign_cycles", 64'(cyc + 5), 64'(10 * (LAT + 1)));
        check("ign_pass", 64'(pass_cnt_o), 64'd10);
        check("ign_fail", 64'(fail_cnt_o), 64'd0);

        // Asynchronous reset after vector 3, then a clean run.
        start_run(32'hCAFE_F00D, CW'(10));
        repeat (7) @(posedge clk);
        #3;
        check("pre_rst_busy", 64'(busy_o), 64'd1);
        rst_n = 1'b0;
        #1;
        check("arst_flags", 64'({busy_o, done_o}), 64'b00);
        check("arst_bus", 64'({bus.A, bus.B, bus.opcode}), 64'd0);
        check("arst_cnts", 64'({pass_cnt_o, fail_cnt_o}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_full(32'h0BAD_5EED, 5);
        check("post_rst_pass", 64'(pass_cnt_o), 64'd5);
        check("post_rst_fail", 64'(fail_cnt_o), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_bist_driver.md
Name: alu_bist_driver

Overview:
- Hardware initiator for the Sequential_ALU operand/result interface. It is the driving and checking end of the same A/B/opcode/Result port set.
- Generates pseudo-random operand/opcode vectors from an LFSR, presents them to the ALU, and samples Result after a fixed latency.
- Compares each Result against an internal golden model and accumulates pass/fail counts.
- Used for on-chip self-test and as a synthesizable stimulus source in the ALU bench.

Parameters:
- WIDTH, 8, operand width of A and B. Legal range 1..14, so that 2*WIDTH+3 <= 32.
- ALU_LATENCY, 1, cycles from the edge where the ALU samples A/B/opcode to Result being valid. Must be >= 1.
- CNT_W, 16, width of num_vectors, pass_cnt and fail_cnt.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request to begin a run. Accepted only in IDLE or DONE.
- seed  in  32  initial LFSR value, latched on accepted start. A seed of 0 is replaced by 32'h1.
- num_vectors  in  CNT_W  number of vectors to run, latched on accepted start.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run completion until the next accepted start.
- A  out  WIDTH  operand A to the ALU, registered.
- B  out  WIDTH  operand B to the ALU, registered.
- opcode  out  3  operation select to the ALU, registered.
- Result  in  WIDTH+1  ALU result.
- pass_cnt  out  CNT_W  number of matching vectors.
- fail_cnt  out  CNT_W  number of mismatching vectors.

Behaviour:
- Reset values: busy=0, done=0, A=0, B=0, opcode=0, pass_cnt=0, fail_cnt=0, LFSR=1, state=IDLE.
- Reset is asynchronous. Asserting rst_n low mid-run aborts the run immediately. No partial counts are kept.
- LFSR: 32-bit Fibonacci, taps 32,22,2,1, shift left with feedback into bit 0. Advances once per issued vector.
- Vector mapping from the current LFSR value L:
  - A = L[WIDTH-1:0]
  - B = L[2*WIDTH-1:WIDTH]
  - opcode = L[31:29]
- Golden model, all results WIDTH+1 bits:
  - 0 ADD: {0,A}+{0,B}; MSB is carry-out.
  - 1 SUB: {0,A}-{0,B} mod 2^(WIDTH+1); MSB is borrow.
  - 2 AND, 3 OR, 4 XOR: zero-extended.
  - 5 NAND: zero-extended; the MSB is 0.
  - 6 SHL: {A,0}.
  - 7 SHR: {0,A>>1}.
- FSM states are IDLE, WAIT and DONE.
- IDLE/DONE, on start:
  - Clear both counters, latch num_vectors and load the LFSR from seed.
  - Set busy=1 and done=0.
  - If num_vectors==0, go to DONE on the next edge (busy=0, done=1).
  - Otherwise, on that same edge, drive vector 0 onto A/B/opcode, store its expected value, and enter WAIT with wait_cnt=0.
- WAIT:
  - wait_cnt increments each cycle.
  - When wait_cnt==ALU_LATENCY, the edge compares Result with the stored expected value, increments pass_cnt or fail_cnt, and decrements the remaining count.
  - If vectors remain, the same edge drives the next vector and resets wait_cnt. Otherwise go to DONE.
- Throughput: one vector per ALU_LATENCY+1 cycles. The vector issued at edge t is checked at edge t+ALU_LATENCY+1.
- A/B/opcode hold their values between issues. They keep the last vector after completion.
- start while busy is ignored.
- Counters saturate at all-ones and never wrap.
- done stays asserted until the next accepted start. busy and done are never both 1.

Optional Feature:
- Macro: ALU_BIST_STOP_ON_FAIL_EN.
- Defined: the first mismatch ends the run. On the compare edge, fail_cnt becomes 1, the FSM enters DONE, and no further vectors are issued. pass_cnt holds the number of vectors that passed before the failure.
- Not defined: mismatches are counted and the run always completes all num_vectors.

Test Plan:
- Correct ALU model, seed=32'hACE1, num_vectors=100 -> done after 1+100*(ALU_LATENCY+1) cycles, pass_cnt=100, fail_cnt=0. A/B/opcode sequence matches a bench-side LFSR mirror.
- ALU with Result stuck at 0, num_vectors=20, macro off -> pass_cnt+fail_cnt=20. fail_cnt equals the number of mirror vectors whose expected value is nonzero.
- Same stuck ALU, macro on -> run halts at the first nonzero-expected vector, fail_cnt=1, done=1, no further opcode changes.
- num_vectors=0 -> done=1 and busy=0 one cycle after start, counters 0. seed=0 with num_vectors=1 -> A/B/opcode derived from L=32'h1 (A=1, B=0, opcode=0).
- start pulsed again at cycle 5 of a 10-vector run -> ignored, final pass_cnt=10.
- rst_n low mid-run (after vector 3) -> all outputs return to reset values asynchronously. A subsequent start runs cleanly from the new seed.
